// File: rtl/usb_cmd_decoder_if.sv
// FTDI byte stream in, register write strobe out; pause_rcv flows back to the FTDI reader.
interface usb_cmd_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pause_rcv;
  logic        wr_stb;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  modport master (output rx_data, rx_valid, input pause_rcv, wr_stb, wr_addr, wr_data);
  modport slave  (input rx_data, rx_valid, output pause_rcv, wr_stb, wr_addr, wr_data);
endinterface

// File: rtl/usb_cmd_decoder.sv
// Parses SYNC/ADDR/DHI/DLO/CSUM frames into 16-bit register writes; wr_stb and reg_q appear the cycle after CSUM.
// Backpressure: pause_rcv is high only in the one-cycle WRITE state, and a byte arriving then is still taken.
module usb_cmd_decoder #(
  parameter int         NREGS   = 4,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  usb_cmd_decoder_if.slave       bus,
  output logic [16*NREGS-1:0]    reg_q,
  output logic [7:0]             err_cnt,
  output logic [7:0]             frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DHI, S_DLO, S_CSUM, S_WRITE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  addr_q, dhi_q, dlo_q;
  logic [15:0] to_cnt;
  logic        in_frame, timeout, frame_ok, frame_bad;

  always_comb begin
    in_frame  = (state == S_ADDR) || (state == S_DHI) || (state == S_DLO) || (state == S_CSUM);
    timeout   = in_frame && !bus.rx_valid && (to_cnt == 16'(TIMEOUT - 1));
    frame_ok  = (state == S_CSUM) && bus.rx_valid &&
                (bus.rx_data == (addr_q ^ dhi_q ^ dlo_q)) &&
                (addr_q[7:4] == 4'd0) &&
                ({1'b0, addr_q[3:0]} < 5'(NREGS));
    frame_bad = (state == S_CSUM) && bus.rx_valid && !frame_ok;
  end

  always_comb begin
    state_nxt     = state;
    bus.pause_rcv = 1'b0;
    case (state)
      S_IDLE:  if (bus.rx_valid && bus.rx_data == SYNC) state_nxt = S_ADDR;
      S_ADDR:  if (bus.rx_valid) state_nxt = S_DHI;
      S_DHI:   if (bus.rx_valid) state_nxt = S_DLO;
      S_DLO:   if (bus.rx_valid) state_nxt = S_CSUM;
      S_CSUM:  if (bus.rx_valid) state_nxt = frame_ok ? S_WRITE : S_IDLE;
      S_WRITE: begin
        bus.pause_rcv = 1'b1;
        // A SYNC landing on the write cycle starts the next frame without loss.
        state_nxt = (bus.rx_valid && bus.rx_data == SYNC) ? S_ADDR : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (timeout) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      to_cnt <= '0;
      addr_q <= '0;
      dhi_q <= '0;
      dlo_q <= '0;
    end else begin
      state <= state_nxt;
      to_cnt <= (bus.rx_valid || !in_frame) ? 16'd0 : to_cnt + 16'd1;
      if (bus.rx_valid) begin
        if (state == S_ADDR) addr_q <= bus.rx_data;
        if (state == S_DHI)  dhi_q  <= bus.rx_data;
        if (state == S_DLO)  dlo_q  <= bus.rx_data;
      end
    end
  end

  // The write is committed on the edge that enters WRITE, so reg_q, wr_stb and
  // frame_cnt all become visible together during the WRITE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_stb  <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      reg_q       <= '0;
      err_cnt     <= '0;
      frame_cnt   <= '0;
    end else begin
      bus.wr_stb <= frame_ok;
      if (frame_ok) begin
        bus.wr_addr <= addr_q[3:0];
        bus.wr_data <= {dhi_q, dlo_q};
        frame_cnt   <= frame_cnt + 8'd1;
        for (int k = 0; k < NREGS; k++) begin
          if (addr_q[3:0] == 4'(k)) reg_q[16*k +: 16] <= {dhi_q, dlo_q};
        end
      end
      if ((frame_bad || timeout) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// Directed-vector bench for usb_cmd_decoder: drives bytes on the falling edge, samples on the falling edge.
module tb_usb_cmd_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] reg_q;
  logic [7:0]  err_cnt, frame_cnt;
  int          n_cmp = 0, n_bad = 0, stb_cnt = 0, stb_base;

  usb_cmd_decoder_if bus ();

  usb_cmd_decoder #(.NREGS(4), .SYNC(8'hA5), .TIMEOUT(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .reg_q     (reg_q),
    .err_cnt   (err_cnt),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && bus.wr_stb) stb_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("rst_pause", bus.pause_rcv, 0);
    chk("rst_stb", bus.wr_stb, 0);
    chk("rst_addr", bus.wr_addr, 0);
    chk("rst_data", bus.wr_data, 0);
    chk("rst_regs", reg_q, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_frame", frame_cnt, 0);

    // Basic write; checked in the cycle right after the CSUM byte
    send5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27);
    idle(1);
    chk("t1_stb", bus.wr_stb, 1);
    chk("t1_pause", bus.pause_rcv, 1);
    chk("t1_addr", bus.wr_addr, 1);
    chk("t1_data", bus.wr_data, 16'h1234);
    chk("t1_reg1", reg_q[31:16], 16'h1234);
    chk("t1_frame", frame_cnt, 1);
    idle(1);
    chk("t1_stb_off", bus.wr_stb, 0);
    chk("t1_pause_off", bus.pause_rcv, 0);
    chk("t1_data_hold", bus.wr_data, 16'h1234);

    // Bad checksum, then recovery
    send5(8'hA5, 8'h00, 8'h00, 8'h01, 8'h00);
    idle(1);
    chk("t2_stb", bus.wr_stb, 0);
    chk("t2_err", err_cnt, 1);
    chk("t2_reg0", reg_q[15:0], 0);
    send5(8'hA5, 8'h00, 8'hBE, 8'hEF, 8'h51);
    idle(1);
    chk("t2_reg0_ok", reg_q[15:0], 16'hBEEF);
    chk("t2_frame", frame_cnt, 2);

    // Out-of-range and nonzero-upper-nibble addresses
    send5(8'hA5, 8'h04, 8'h00, 8'h00, 8'h04);
    idle(1);
    chk("t3_stb_a4", bus.wr_stb, 0);
    chk("t3_err_a4", err_cnt, 2);
    send5(8'hA5, 8'h10, 8'h00, 8'h00, 8'h10);
    idle(1);
    chk("t3_err_a10", err_cnt, 3);
    chk("t3_frame", frame_cnt, 2);

    // Garbage before sync is dropped silently
    idle(2);
    stb_base = stb_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send5(8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64);
    idle(1);
    chk("t4_stb", bus.wr_stb, 1);
    chk("t4_reg2", reg_q[47:32], 16'hABCD);
    chk("t4_err", err_cnt, 3);
    idle(2);
    chk("t4_nstb", stb_cnt - stb_base, 1);

    // Inter-byte timeout
    send_byte(8'hA5); send_byte(8'h03);
    idle(1020);
    chk("t5_err_early", err_cnt, 3);
    idle(10);
    chk("t5_err_to", err_cnt, 4);
    send5(8'hA5, 8'h03, 8'h12, 8'h34, 8'h25);
    idle(1);
    chk("t5_reg3", reg_q[63:48], 16'h1234);
    chk("t5_frame", frame_cnt, 4);

    // Back-to-back frames, second SYNC arrives in the WRITE cycle
    idle(2);
    stb_base = stb_cnt;
    send5(8'hA5, 8'h01, 8'h55, 8'hAA, 8'hFE);
    send5(8'hA5, 8'h02, 8'h0F, 8'hF0, 8'hFD);
    idle(3);
    chk("t6_nstb", stb_cnt - stb_base, 2);
    chk("t6_reg1", reg_q[31:16], 16'h55AA);
    chk("t6_reg2", reg_q[47:32], 16'h0FF0);
    chk("t6_frame", frame_cnt, 6);

    // Reset in the middle of a frame
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h77);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_regs", reg_q, 0);
    chk("t6_rst_err", err_cnt, 0);
    chk("t6_rst_frame", frame_cnt, 0);
    chk("t6_rst_stb", bus.wr_stb, 0);
    idle(2);
    rst = 1'b0;
    stb_base = stb_cnt;
    idle(4);
    chk("t6_no_stray", stb_cnt - stb_base, 0);
    chk("t6_err_after", err_cnt, 0);
    send5(8'hA5, 8'h00, 8'h12, 8'h34, 8'h26);
    idle(1);
    chk("t6_reg0_after", reg_q[15:0], 16'h1234);
    chk("t6_frame_after", frame_cnt, 1);

    // Saturation of err_cnt and wrap of frame_cnt
    for (int i = 0; i < 256; i++) send5(8'hA5, 8'h04, 8'h00, 8'h00, 8'h04);
    idle(2);
    chk("sat_err", err_cnt, 8'hFF);
    for (int i = 0; i < 256; i++) send5(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01);
    idle(2);
    chk("wrap_frame", frame_cnt, 1);
    chk("wrap_err", err_cnt, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
